// File: rtl/uart_rx_fsm.sv
// UART receiver: oversamples the serial line, majority-votes each bit, deserializes LSB-first,
// checks optional parity and the stop bit, and emits a one-cycle valid or error strobe.
module uart_rx_fsm #(
  parameter int FRAME_WIDTH = 8,
  parameter int PRESCALE    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   RX_IN,
  input  logic                   par_en,
  input  logic                   par_typ,
  output logic [FRAME_WIDTH-1:0] P_DATA,
  output logic                   data_valid,
  output logic                   par_err,
  output logic                   stp_err,
  output logic                   busy
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_reg, state_next;
  logic [EW-1:0]          edge_cnt_reg, edge_cnt_next;
  logic [BW-1:0]          bit_cnt_reg, bit_cnt_next;
  logic [2:0]             sample_reg, sample_next;
  logic [FRAME_WIDTH-1:0] shift_reg, shift_next;
  logic                   par_en_reg, par_en_next;
  logic                   par_typ_reg, par_typ_next;
  logic                   par_pend_reg, par_pend_next;
  logic [FRAME_WIDTH-1:0] p_data_reg, p_data_next;
  logic                   data_valid_reg, data_valid_next;
  logic                   par_err_reg, par_err_next;
  logic                   stp_err_reg, stp_err_next;

  logic [2:0] sample_hit;
  logic       bit_end;
  logic       bit_val;

  // Three sample points straddle the bit centre.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sample
      assign sample_hit[gi] = (edge_cnt_reg == EW'(PRESCALE / 2 - 1 + gi));
    end
  endgenerate

  assign bit_end = (edge_cnt_reg == EDGE_LAST);
  assign bit_val = (sample_reg[0] & sample_reg[1]) | (sample_reg[0] & sample_reg[2]) |
                   (sample_reg[1] & sample_reg[2]);

  always_comb begin
    state_next      = state_reg;
    edge_cnt_next   = bit_end ? '0 : edge_cnt_reg + 1'b1;
    bit_cnt_next    = bit_cnt_reg;
    sample_next     = sample_reg;
    shift_next      = shift_reg;
    par_en_next     = par_en_reg;
    par_typ_next    = par_typ_reg;
    par_pend_next   = par_pend_reg;
    p_data_next     = p_data_reg;
    data_valid_next = 1'b0;
    par_err_next    = 1'b0;
    stp_err_next    = 1'b0;

    for (int i = 0; i < 3; i++) begin
      if (sample_hit[i]) sample_next[i] = RX_IN;
    end

    case (state_reg)
      S_IDLE: begin
        edge_cnt_next = '0;
        if (!RX_IN) begin
          // The detect cycle is edge 0 of the start bit.
          state_next    = S_START;
          edge_cnt_next = EW'(1);
          par_en_next   = par_en;
          par_typ_next  = par_typ;
          par_pend_next = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          if (bit_val) begin
            state_next = S_IDLE;
          end else begin
            state_next   = S_DATA;
            bit_cnt_next = '0;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_next = {bit_val, shift_reg[FRAME_WIDTH-1:1]};
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = par_en_reg ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          par_pend_next = (bit_val != ((^shift_reg) ^ par_typ_reg));
          state_next    = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (par_pend_reg || !bit_val) begin
            par_err_next = par_pend_reg;
            stp_err_next = !bit_val;
          end else begin
            data_valid_next = 1'b1;
            p_data_next     = shift_reg;
          end
          if (!RX_IN) begin
            state_next    = S_START;
            edge_cnt_next = EW'(1);
            par_en_next   = par_en;
            par_typ_next  = par_typ;
            par_pend_next = 1'b0;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next    = S_IDLE;
        edge_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      edge_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      sample_reg     <= '0;
      shift_reg      <= '0;
      par_en_reg     <= 1'b0;
      par_typ_reg    <= 1'b0;
      par_pend_reg   <= 1'b0;
      p_data_reg     <= '0;
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      edge_cnt_reg   <= edge_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      sample_reg     <= sample_next;
      shift_reg      <= shift_next;
      par_en_reg     <= par_en_next;
      par_typ_reg    <= par_typ_next;
      par_pend_reg   <= par_pend_next;
      p_data_reg     <= p_data_next;
      data_valid_reg <= data_valid_next;
      par_err_reg    <= par_err_next;
      stp_err_reg    <= stp_err_next;
    end
  end

  assign P_DATA     = p_data_reg;
  assign data_valid = data_valid_reg;
  assign par_err    = par_err_reg;
  assign stp_err    = stp_err_reg;
  assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: a table of whole frames plus hand-written glitch,
// back-to-back and mid-frame reset sequences.
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nv = 0, npe = 0, nse = 0, nboth = 0;
  int last_vcyc = 0, prev_vcyc = 0;
  int fstart = 0;

  uart_rx_fsm #(.FRAME_WIDTH(8), .PRESCALE(8)) dut (
    .clk(clk), .reset(reset), .RX_IN(rx), .par_en(par_en), .par_typ(par_typ),
    .P_DATA(p_data), .data_valid(data_valid), .par_err(par_err),
    .stp_err(stp_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (data_valid) begin
      nv <= nv + 1;
      prev_vcyc <= last_vcyc;
      last_vcyc <= cyc;
    end
    if (par_err) npe <= npe + 1;
    if (stp_err) nse <= nse + 1;
    if (par_err && stp_err) nboth <= nboth + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       ptyp;
    logic       pbit;
    logic       sbit;
    int         glitch;
    int         exp_v;
    int         exp_pe;
    int         exp_se;
    int         exp_both;
    logic [7:0] exp_pd;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic v, input bit gl);
    for (int j = 0; j < 8; j++) begin
      rx = (gl && j == 4) ? 1'b0 : v;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic sbit, input int glitch, input int idle);
    fstart = cyc;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch == i);
    if (pen) send_bit(pbit, 1'b0);
    send_bit(sbit, 1'b0);
    rx = 1'b1;
    repeat (idle) @(negedge clk);
  endtask

  initial begin
    int s_v, s_pe, s_se, s_both;
    logic b7, b8;
    b7 = 1'b0;
    b8 = 1'b0;
    rx = 1'b1; reset = 1'b0; par_en = 1'b0; par_typ = 1'b0;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1, 0, 0, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1, 0, 0, 0, 8'h3C};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 1, 0, 0, 8'h3C};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, 0, 1, 0, 8'h3C};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, -1, 0, 1, 1, 1, 8'h3C};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1, 0, 0, 0, 8'hFF};
    vecs[6] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1, 0, 0, 0, 8'hC3};

    repeat (3) @(negedge clk);
    check("reset_pdata", 32'(p_data), 0);
    check("reset_valid", 32'(data_valid), 0);
    check("reset_perr", 32'(par_err), 0);
    check("reset_serr", 32'(stp_err), 0);
    check("reset_busy", 32'(busy), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      s_v = nv; s_pe = npe; s_se = nse; s_both = nboth;
      par_en = vecs[i].pen; par_typ = vecs[i].ptyp;
      send_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].sbit, vecs[i].glitch, 12);
      check($sformatf("v%0d_valid", i), 32'(nv - s_v), 32'(vecs[i].exp_v));
      check($sformatf("v%0d_perr", i), 32'(npe - s_pe), 32'(vecs[i].exp_pe));
      check($sformatf("v%0d_serr", i), 32'(nse - s_se), 32'(vecs[i].exp_se));
      check($sformatf("v%0d_both", i), 32'(nboth - s_both), 32'(vecs[i].exp_both));
      check($sformatf("v%0d_pdata", i), 32'(p_data), 32'(vecs[i].exp_pd));
      if (i == 0) check("v0_latency", 32'(last_vcyc - fstart), 80);
      $display("frame %0d data=%02h pen=%0d p_data=%02h valid=%0d perr=%0d serr=%0d",
               i, vecs[i].data, vecs[i].pen, p_data, nv - s_v, npe - s_pe, nse - s_se);
    end

    // Short start glitch: 3 clocks low, then high.
    par_en = 1'b0; par_typ = 1'b0;
    s_v = nv; s_pe = npe; s_se = nse;
    rx = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k >= 3) rx = 1'b1;
      if (k == 7) b7 = busy;
      if (k == 8) b8 = busy;
    end
    check("glitch_busy_e6", 32'(b7), 1);
    check("glitch_busy_e7", 32'(b8), 0);
    check("glitch_strobes", 32'((nv - s_v) + (npe - s_pe) + (nse - s_se)), 0);
    $display("start glitch: busy before/after bit end=%0d/%0d", b7, b8);

    // Back-to-back frames with no idle between them.
    s_v = nv;
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, -1, 0);
    check("b2b_first_pdata", 32'(p_data), 32'h01);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, -1, 12);
    check("b2b_valid_cnt", 32'(nv - s_v), 2);
    check("b2b_spacing", 32'(last_vcyc - prev_vcyc), 80);
    check("b2b_second_pdata", 32'(p_data), 32'hFE);
    $display("back-to-back: valids=%0d spacing=%0d p_data=%02h", nv - s_v, last_vcyc - prev_vcyc, p_data);

    // Reset in the middle of data bit 4.
    s_v = nv; s_pe = npe; s_se = nse;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_pdata", 32'(p_data), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(data_valid), 0);
    check("midrst_perr", 32'(par_err), 0);
    check("midrst_serr", 32'(stp_err), 0);
    reset = 1'b1; rx = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, -1, 12);
    check("post_rst_valid", 32'(nv - s_v), 1);
    check("post_rst_errs", 32'((npe - s_pe) + (nse - s_se)), 0);
    check("post_rst_pdata", 32'(p_data), 32'h81);
    $display("after mid-frame reset: p_data=%02h valids=%0d", p_data, nv - s_v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
